updown_sweep_ctrl: RTL and testbench

Sequencing controller for an up/down loadable counter. Accepts a sweep command (start value, end value, pass count) over a valid/ready handshake, loads the counter, steps it toward the end value, and optionally ping-pongs between the two endpoints for a programmed number of passes. It sits between command-issuing logic and the counter datapath, and replaces hand-driven load/dir control.

---
 rtl/udsweep_pkg.sv | 18 +
 rtl/updown_sweep_ctrl_if.sv | 38 +++
 rtl/updown_ctr.sv | 37 +++
 rtl/updown_sweep_ctrl.sv | 125 ++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/udsweep_pkg.sv
// Shared types and constants for the up/down sweep controller.
// Contents: FSM state enum, default widths, direction encoding.
package udsweep_pkg;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefPassW = 4;

    localparam logic DirUp   = 1'b1;
    localparam logic DirDown = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// Command and status bundle between a command issuer and updown_sweep_ctrl.
// master: drives cmd_valid/cmd_start/cmd_end/cmd_passes/abort (and pause when
//         UDSWEEP_PAUSE_EN is defined); observes cmd_ready/count/busy/done/aborted.
// slave:  the controller side, mirror image of master.
interface updown_sweep_ctrl_if #(
    parameter int unsigned WIDTH  = udsweep_pkg::DefWidth,
    parameter int unsigned PASS_W = udsweep_pkg::DefPassW
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [WIDTH-1:0]  cmd_start;
    logic [WIDTH-1:0]  cmd_end;
    logic [PASS_W-1:0] cmd_passes;
    logic              abort;
`ifdef UDSWEEP_PAUSE_EN
    logic              pause;
`endif
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
`ifdef UDSWEEP_PAUSE_EN
        output pause,
`endif
        output cmd_valid, cmd_start, cmd_end, cmd_passes, abort,
        input  cmd_ready, count, busy, done, aborted
    );

    modport slave (
`ifdef UDSWEEP_PAUSE_EN
        input  pause,
`endif
        input  cmd_valid, cmd_start, cmd_end, cmd_passes, abort,
        output cmd_ready, count, busy, done, aborted
    );
endinterface

// File: rtl/updown_ctr.sv
// Loadable up/down counter.
// Ports: clk, rst (async, active-high), load (loads l_data, wins over en),
//        en (step one in direction dir), dir (1 = up, 0 = down), count.
import udsweep_pkg::*;

module updown_ctr #(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] l_data,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = l_data;
        end else if (en) begin
            count_d = (dir == DirUp) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for an up/down counter: accepts (start, end, passes), loads the
// counter with start, steps toward end and optionally ping-pongs between the two
// endpoints for the programmed number of passes.
// Ports: clk, rst (async, active-high), bus (updown_sweep_ctrl_if.slave).
// Optional feature: define UDSWEEP_PAUSE_EN to add the pause input (freezes RUN).
import udsweep_pkg::*;

module updown_sweep_ctrl #(
    parameter int unsigned WIDTH  = DefWidth,
    parameter int unsigned PASS_W = DefPassW
) (
    input logic                  clk,
    input logic                  rst,
    updown_sweep_ctrl_if.slave   bus
);
    state_e            state_q, state_d;
    logic [WIDTH-1:0]  target_q, target_d;
    // Endpoint opposite the target; holds start until the first reversal.
    logic [WIDTH-1:0]  other_q, other_d;
    logic              dir_q, dir_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic              aborted_q, aborted_d;

    logic              ctr_load, ctr_en;
    logic [WIDTH-1:0]  count_w;
    logic              pause_w;

`ifdef UDSWEEP_PAUSE_EN
    assign pause_w = bus.pause;
`else
    assign pause_w = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        other_d   = other_q;
        dir_d     = dir_q;
        passes_d  = passes_q;
        ctr_load  = 1'b0;
        ctr_en    = 1'b0;
        aborted_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    target_d = bus.cmd_end;
                    other_d  = bus.cmd_start;
                    dir_d    = (bus.cmd_end >= bus.cmd_start) ? DirUp : DirDown;
                    passes_d = (bus.cmd_passes == '0) ? PASS_W'(1) : bus.cmd_passes;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    ctr_load = 1'b1;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = StIdle;
                end else if (!pause_w) begin
                    if (count_w != target_q) begin
                        ctr_en = 1'b1;
                    end else if (passes_q == PASS_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        // Reversal cycle: counter holds while endpoints swap.
                        target_d = other_q;
                        other_d  = target_q;
                        dir_d    = ~dir_q;
                        passes_d = passes_q - PASS_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            target_q  <= '0;
            other_q   <= '0;
            dir_q     <= DirUp;
            passes_q  <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            other_q   <= other_d;
            dir_q     <= dir_d;
            passes_q  <= passes_d;
            aborted_q <= aborted_d;
        end
    end

    updown_ctr #(
        .WIDTH (WIDTH)
    ) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .load   (ctr_load),
        .en     (ctr_en),
        .dir    (dir_q),
        .l_data (other_q),
        .count  (count_w)
    );

    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.count     = count_w;
    assign bus.busy      = (state_q == StLoad) || (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.aborted   = aborted_q;
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed self-checking bench for updown_sweep_ctrl. Cycle k counts clock cycles
// after the accept cycle k=0; outputs are sampled 1 time unit after each rising edge.
module tb_updown_sweep_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    updown_sweep_ctrl_if #(.WIDTH(4), .PASS_W(4)) bus ();

    updown_sweep_ctrl #(
        .WIDTH  (4),
        .PASS_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] s, input logic [3:0] e, input logic [3:0] p);
        bus.cmd_start  = s;
        bus.cmd_end    = e;
        bus.cmd_passes = p;
        bus.cmd_valid  = 1'b1;
    endtask

    task automatic test_reset();
        total++;
        if (bus.count !== 4'd0) begin
            bad++; $display("FAIL reset_count got=%0d want=0", bus.count);
        end
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got busy=%b done=%b aborted=%b want 0,0,0",
                     bus.busy, bus.done, bus.aborted);
        end
        total++;
        if (bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b want=1", bus.cmd_ready);
        end
    endtask

    task automatic test_single_up();
        logic [3:0] exp_cnt [0:7] = '{0, 0, 3, 4, 5, 6, 7, 7};
        step();
        issue(4'd3, 4'd7, 4'd1);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) bus.cmd_valid = 1'b0;
            if (k >= 2) begin
                total++;
                if (bus.count !== exp_cnt[k]) begin
                    bad++; $display("FAIL up_count k=%0d got=%0d want=%0d", k, bus.count, exp_cnt[k]);
                end
            end
            total++;
            if (bus.done !== (k == 7)) begin
                bad++; $display("FAIL up_done k=%0d got=%b want=%b", k, bus.done, (k == 7));
            end
            total++;
            if (bus.busy !== (k < 7)) begin
                bad++; $display("FAIL up_busy k=%0d got=%b want=%b", k, bus.busy, (k < 7));
            end
        end
    endtask

    task automatic test_pingpong_down();
        logic [3:0] exp_cnt [0:11] = '{0, 0, 10, 9, 8, 8, 9, 10, 10, 9, 8, 8};
        step();
        issue(4'd10, 4'd8, 4'd3);
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 1) bus.cmd_valid = 1'b0;
            if (k >= 2) begin
                total++;
                if (bus.count !== exp_cnt[k]) begin
                    bad++; $display("FAIL pp_count k=%0d got=%0d want=%0d", k, bus.count, exp_cnt[k]);
                end
            end
            total++;
            if (bus.done !== (k == 11)) begin
                bad++; $display("FAIL pp_done k=%0d got=%b want=%b", k, bus.done, (k == 11));
            end
        end
    endtask

    task automatic test_equal_zero_pass();
        step();
        issue(4'd5, 4'd5, 4'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) bus.cmd_valid = 1'b0;
            total++;
            if (bus.done !== (k == 3)) begin
                bad++; $display("FAIL eq_done k=%0d got=%b want=%b", k, bus.done, (k == 3));
            end
        end
        total++;
        if (bus.count !== 4'd5) begin
            bad++; $display("FAIL eq_count got=%0d want=5", bus.count);
        end
    endtask

    task automatic test_busy_reject();
        logic [3:0] exp_cnt [0:7] = '{0, 0, 1, 2, 3, 3, 3, 3};
        step();
        issue(4'd1, 4'd3, 4'd1);
        for (int k = 1; k <= 7; k++) begin
            step();
            // Keep offering a different command while busy; it must be ignored.
            if (k == 1) issue(4'd9, 4'd12, 4'd2);
            if (k == 4) bus.cmd_valid = 1'b0;
            if (k >= 1 && k <= 4) begin
                total++;
                if (bus.cmd_ready !== 1'b0) begin
                    bad++; $display("FAIL rej_ready k=%0d got=%b want=0", k, bus.cmd_ready);
                end
            end
            if (k >= 2) begin
                total++;
                if (bus.count !== exp_cnt[k]) begin
                    bad++; $display("FAIL rej_count k=%0d got=%0d want=%0d", k, bus.count, exp_cnt[k]);
                end
            end
            total++;
            if (bus.done !== (k == 5)) begin
                bad++; $display("FAIL rej_done k=%0d got=%b want=%b", k, bus.done, (k == 5));
            end
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL rej_idle got busy=%b want=0", bus.busy);
        end
    endtask

    task automatic test_abort();
        logic [3:0] exp_cnt [0:12] = '{0, 0, 0, 1, 2, 3, 4, 4, 4, 12, 11, 10, 10};
        step();
        issue(4'd0, 4'd15, 4'd1);
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) bus.cmd_valid = 1'b0;
            if (k >= 2) begin
                total++;
                if (bus.count !== exp_cnt[k]) begin
                    bad++; $display("FAIL ab_count k=%0d got=%0d want=%0d", k, bus.count, exp_cnt[k]);
                end
            end
            total++;
            if (bus.aborted !== (k == 7)) begin
                bad++; $display("FAIL ab_pulse k=%0d got=%b want=%b", k, bus.aborted, (k == 7));
            end
            total++;
            if (bus.done !== (k == 12)) begin
                bad++; $display("FAIL ab_done k=%0d got=%b want=%b", k, bus.done, (k == 12));
            end
            if (k == 6) bus.abort = 1'b1;
            if (k == 7) begin
                bus.abort = 1'b0;
                total++;
                if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL ab_idle got ready=%b busy=%b want 1,0", bus.cmd_ready, bus.busy);
                end
                issue(4'd12, 4'd10, 4'd1);
            end
            if (k == 8) bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic test_abort_in_idle();
        step();
        issue(4'd2, 4'd2, 4'd1);
        bus.abort = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            if (k == 1) begin
                bus.cmd_valid = 1'b0;
                bus.abort     = 1'b0;
                total++;
                if (bus.busy !== 1'b1 || bus.aborted !== 1'b0) begin
                    bad++;
                    $display("FAIL idle_abort got busy=%b aborted=%b want 1,0", bus.busy, bus.aborted);
                end
            end
            total++;
            if (bus.done !== (k == 3)) begin
                bad++; $display("FAIL idle_abort_done k=%0d got=%b want=%b", k, bus.done, (k == 3));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        step();
        issue(4'd2, 4'd9, 4'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) bus.cmd_valid = 1'b0;
        end
        total++;
        if (bus.count !== 4'd5) begin
            bad++; $display("FAIL rst_pre_count got=%0d want=5", bus.count);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_async got count=%0d busy=%b ready=%b want 0,0,1",
                     bus.count, bus.busy, bus.cmd_ready);
        end
        step();
        rst = 1'b0;
        step();
        total++;
        if (bus.count !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL rst_after got count=%0d busy=%b done=%b want 0,0,0",
                     bus.count, bus.busy, bus.done);
        end
    endtask

`ifdef UDSWEEP_PAUSE_EN
    task automatic test_pause();
        logic [3:0] exp_cnt [0:13] = '{0, 0, 2, 3, 4, 5, 6, 6, 6, 6, 7, 8, 9, 9};
        step();
        issue(4'd2, 4'd9, 4'd1);
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 1) bus.cmd_valid = 1'b0;
            if (k >= 2) begin
                total++;
                if (bus.count !== exp_cnt[k]) begin
                    bad++; $display("FAIL pause_count k=%0d got=%0d want=%0d", k, bus.count, exp_cnt[k]);
                end
            end
            total++;
            if (bus.done !== (k == 13)) begin
                bad++; $display("FAIL pause_done k=%0d got=%b want=%b", k, bus.done, (k == 13));
            end
            if (k == 6) bus.pause = 1'b1;
            if (k == 9) bus.pause = 1'b0;
        end
    endtask

    task automatic test_pause_with_abort();
        step();
        issue(4'd0, 4'd5, 4'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) bus.cmd_valid = 1'b0;
            if (k == 3) begin
                bus.pause = 1'b1;
                bus.abort = 1'b1;
            end
        end
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.aborted !== 1'b1 || bus.count !== 4'd1) begin
            bad++;
            $display("FAIL pause_abort got busy=%b aborted=%b count=%0d want 0,1,1",
                     bus.busy, bus.aborted, bus.count);
        end
    endtask
`endif

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_start  = '0;
        bus.cmd_end    = '0;
        bus.cmd_passes = '0;
        bus.abort      = 1'b0;
`ifdef UDSWEEP_PAUSE_EN
        bus.pause      = 1'b0;
`endif
        #1;
        test_reset();
        step();
        step();
        rst = 1'b0;
        test_reset();
        test_single_up();
        test_pingpong_down();
        test_equal_zero_pass();
        test_busy_reject();
        test_abort();
        test_abort_in_idle();
        test_reset_mid_run();
`ifdef UDSWEEP_PAUSE_EN
        test_pause();
        test_pause_with_abort();
`endif
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
